// File: rtl/alu_pkg.sv
// Shared opcode map and control-state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_ROTL = 4'd8;
  localparam logic [3:0] OP_ROTR = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// Radix-2 shift-add signed multiplier: magnitudes are multiplied over WIDTH
// cycles, the sign is applied combinationally on the finished product.
module alu_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;

  // Most-negative input maps to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(WIDTH);
    end else if (busy) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      else           busy <= 1'b0;
    end
  end

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  end

  // Multiplier bits sit in the low half and are consumed LSB first.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand <= magnitude(a);
      acc   <= {{WIDTH{1'b0}}, magnitude(b)};
      neg   <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (busy && cnt != '0) begin
      acc   <= {sum, acc[WIDTH-1:1]};
    end
  end

  assign done    = busy && (cnt == '0);
  assign product = neg ? -acc : acc;

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU with valid/ready handshakes; single-cycle ops complete on the
// accept edge, MUL runs on the sequential multiplier and stalls the input side.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             Error
);

  state_t state, state_nxt;

  logic                    accept, is_mul, mul_start, mul_busy, mul_done, mul_fin;
  logic [2*WIDTH-1:0]      mul_product;
  logic [SHW-1:0]          sh;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum, diff, op_res;
  logic [2*WIDTH-1:0]      rotl_w, rotr_w;
  logic                    op_ovf, op_err;

  assign sh        = B[SHW-1:0];
  assign a_s       = A;
  assign b_s       = B;
  assign InReady   = (state == IDLE) && (!OutValid || OutReady);
  assign accept    = InValid && InReady;
  assign is_mul    = (ALUControl == OP_MUL);
  assign mul_start = accept && is_mul;
  assign mul_fin   = (state == BUSY) && mul_busy && mul_done;

  always_comb begin
    sum    = A + B;
    diff   = A - B;
    rotl_w = {A, A} << sh;
    rotr_w = {A, A} >> sh;
    op_res = '0;
    op_ovf = 1'b0;
    op_err = 1'b0;
    case (ALUControl)
      OP_AND:  op_res = A & B;
      OP_OR:   op_res = A | B;
      OP_ADD: begin
        op_res = sum;
        op_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  op_res = A ^ B;
      OP_SLL:  op_res = A << sh;
      OP_SRL:  op_res = A >> sh;
      OP_SUB: begin
        op_res = diff;
        op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_ROTL: op_res = rotl_w[2*WIDTH-1:WIDTH];
      OP_ROTR: op_res = rotr_w[WIDTH-1:0];
      OP_SRA:  op_res = a_s >>> sh;
      OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_NOR:  op_res = ~(A | B);
      OP_MUL:  op_res = '0;
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mul_start) state_nxt = BUSY;
      BUSY: if (mul_fin)   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Result registers: data only moves on an accept or a multiply completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      OutValid  <= 1'b0;
      ALUResult <= '0;
      Hi        <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Error     <= 1'b0;
    end else if (accept && !is_mul) begin
      OutValid  <= 1'b1;
      ALUResult <= op_res;
      Hi        <= '0;
      Zero      <= (op_res == '0);
      Overflow  <= op_ovf;
      Error     <= op_err;
    end else if (accept) begin
      OutValid  <= 1'b0;
    end else if (mul_fin) begin
      OutValid  <= 1'b1;
      ALUResult <= mul_product[WIDTH-1:0];
      Hi        <= mul_product[2*WIDTH-1:WIDTH];
      Zero      <= (mul_product[WIDTH-1:0] == '0);
      Overflow  <= 1'b0;
      Error     <= 1'b0;
    end else if (OutValid && OutReady) begin
      OutValid  <= 1'b0;
    end
  end

  alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expected results,
// an independent monitor pops them whenever a result is taken.
module tb_alu_multicycle;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         err;
  } exp_t;

  logic         Clk, Reset_n, InValid, InReady, OutValid, OutReady;
  logic         Zero, Overflow, Error;
  logic [3:0]   ALUControl;
  logic [W-1:0] A, B, ALUResult, Hi;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   edge_cnt = 0;
  exp_t sb_q[$];

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .A(A), .B(B), .OutValid(OutValid),
    .OutReady(OutReady), .ALUResult(ALUResult), .Hi(Hi), .Zero(Zero),
    .Overflow(Overflow), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  function automatic exp_t mk(input logic [W-1:0] res, input logic [W-1:0] hi,
                              input logic ovf, input logic err);
    exp_t e;
    e.res = res; e.hi = hi; e.ovf = ovf; e.err = err; e.zero = (res == 0);
    return e;
  endfunction

  // Reference model: plain 64-bit signed arithmetic on the opcode rules.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, s;
    int     sh;
    sa = $signed(a); sb = $signed(b); sh = int'(b[4:0]);
    e = '0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  begin s = sa + sb; e.res = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3:  e.res = a ^ b;
      4'd4:  e.res = a << sh;
      4'd5:  e.res = a >> sh;
      4'd6:  begin s = sa - sb; e.res = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  e.res = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'd9:  e.res = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      4'd10: begin s = sa >>> sh; e.res = s[31:0]; end
      4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd12: e.res = ~(a | b);
      4'd15: begin s = sa * sb; e.res = s[31:0]; e.hi = s[63:32]; end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    chk_cnt++;
    if (got === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, req);
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t e, input bit rnd, input bit rdy,
                          output int acc_edge, output int tries);
    acc_edge = -1;
    tries    = 0;
    while (acc_edge < 0 && tries < 300) begin
      @(negedge Clk);
      InValid = 1'b1; ALUControl = op; A = a; B = b;
      OutReady = rnd ? ($urandom_range(0, 3) != 0) : rdy;
      #3;
      tries++;
      if (InReady) begin
        acc_edge = edge_cnt + 1;
        sb_q.push_back(e);
      end
    end
    if (acc_edge < 0) begin
      chk_cnt++;
      $display("FAIL accept_timeout: op %0d got no InReady, required accept within 300 cycles", op);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      InValid = 1'b0; OutReady = 1'b1;
      #3;
    end
  endtask

  task automatic wait_mul(input int acc_edge, input string nm);
    int lat;
    bit rdy_seen;
    lat = -1; rdy_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      InValid = 1'b0; OutReady = 1'b1;
      #3;
      if (OutValid) begin lat = edge_cnt - acc_edge; break; end
      if (InReady) rdy_seen = 1'b1;
    end
    check({nm, "_latency"}, 64'(lat), 64'd33);
    check({nm, "_inready_low"}, 64'(rdy_seen), 64'd0);
  endtask

  // Monitor: a result is taken on any edge where OutValid && OutReady.
  initial begin
    exp_t g, e;
    forever begin
      @(negedge Clk);
      #3;
      if (Reset_n && OutValid && OutReady) begin
        g.res = ALUResult; g.hi = Hi; g.zero = Zero; g.ovf = Overflow; g.err = Error;
        chk_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected: got res=%h hi=%h with no result outstanding", g.res, g.hi);
        end else begin
          e = sb_q.pop_front();
          if (g === e) pass_cnt++;
          else $display("FAIL sb_result: got res=%h hi=%h z=%b v=%b e=%b required res=%h hi=%h z=%b v=%b e=%b",
                        g.res, g.hi, g.zero, g.ovf, g.err, e.res, e.hi, e.zero, e.ovf, e.err);
        end
      end
    end
  end

  initial begin
    int   ae, tr, e0, bubbles, changed, rdy_seen;
    logic [3:0]   op;
    logic [W-1:0] ra, rb;
    logic [3*W+3:0] snap;
    logic [3:0] ops1 [5];
    logic [W-1:0] res1 [5];

    Reset_n = 1'b1; InValid = 1'b0; ALUControl = '0; A = '0; B = '0; OutReady = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    check("reset_outputs", {OutValid, ALUResult, Hi, Zero, Overflow, Error}, '0);
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    #3;
    check("inready_after_reset", 64'(InReady), 64'd1);

    // Basic ops back-to-back
    ops1 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
    res1 = '{32'd8, 32'd734, 32'd742, 32'd726, 32'd690};
    bubbles = 0; e0 = 0;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops1[i], 32'd716, 32'd26, mk(res1[i], 0, 0, 0), 1'b0, 1'b1, ae, tr);
      if (i == 0) e0 = ae;
      else if (!OutValid) bubbles++;
    end
    check("b2b_edges", 64'(ae - e0), 64'd4);
    check("b2b_bubbles", 64'(bubbles), 64'd0);
    @(negedge Clk); InValid = 1'b0; #3;
    check("latency1_valid", 64'(OutValid), 64'd1);

    // Shifts, rotates, compares, overflow, illegal
    drive_op(4'd4, 32'd716, 32'd26, mk(32'h3000_0000, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd9, 32'hDD6A_D59A, 32'd4, mk(32'hADD6_AD59, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd8, 32'h1234_5678, 32'd0, mk(32'h1234_5678, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd10, 32'h8000_0000, 32'd31, mk(32'hFFFF_FFFF, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd11, 32'd1, 32'hFFFF_FFFF, mk(32'd1, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd7, 32'd1, 32'hFFFF_FFFF, mk(32'd0, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd2, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 0, 1, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd6, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 0, 1, 0), 1'b0, 1'b1, ae, tr);
    drive_op(4'd14, 32'd5, 32'd7, mk(32'd0, 0, 0, 1), 1'b0, 1'b1, ae, tr);
    drive_op(4'd13, 32'd5, 32'd7, mk(32'd0, 0, 0, 1), 1'b0, 1'b1, ae, tr);

    // Multiply
    drive_op(4'd15, 32'd716, 32'd26, mk(32'h0000_48B8, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    wait_mul(ae, "mul_pos");
    drive_op(4'd15, -32'sd3, 32'd5, mk(32'hFFFF_FFF1, 32'hFFFF_FFFF, 0, 0), 1'b0, 1'b1, ae, tr);
    wait_mul(ae, "mul_neg");
    drive_op(4'd15, 32'h8000_0000, 32'h8000_0000, mk(32'h0, 32'h4000_0000, 0, 0), 1'b0, 1'b1, ae, tr);
    wait_mul(ae, "mul_minneg");

    // Output hold under back-pressure
    drive_op(4'd2, 32'd5, 32'd6, mk(32'd11, 0, 0, 0), 1'b0, 1'b0, ae, tr);
    changed = 0; rdy_seen = 0;
    @(negedge Clk);
    InValid = 1'b1; ALUControl = 4'd1; A = 32'hFFFF; B = 32'h1; OutReady = 1'b0;
    #3;
    snap = {OutValid, ALUResult, Hi, Zero, Overflow, Error};
    check("hold_valid", 64'(OutValid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk); #3;
      if ({OutValid, ALUResult, Hi, Zero, Overflow, Error} !== snap) changed++;
      if (InReady) rdy_seen++;
    end
    check("hold_stable", 64'(changed), 64'd0);
    check("hold_inready", 64'(rdy_seen), 64'd0);
    drive_op(4'd3, 32'h1234, 32'h00FF, mk(32'h12CB, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    check("accept_on_ready_rise", 64'(tr), 64'd1);

    // Asynchronous reset in the middle of a multiply
    drive_op(4'd15, 32'd1234, 32'd5678, model(4'd15, 32'd1234, 32'd5678), 1'b0, 1'b1, ae, tr);
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk); InValid = 1'b0; #3;
    end
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {OutValid, ALUResult, Hi, Zero, Overflow, Error}, '0);
    sb_q.delete();
    @(negedge Clk);
    Reset_n = 1'b1;
    #3;
    check("inready_after_abort", 64'(InReady), 64'd1);
    drive_op(4'd2, 32'd100, 32'd200, mk(32'd300, 0, 0, 0), 1'b0, 1'b1, ae, tr);
    @(negedge Clk); InValid = 1'b0; #3;
    check("post_reset_valid", 64'(OutValid), 64'd1);
    idle(40);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 90; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = pick();
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : pick();
      drive_op(op, ra, rb, model(op, ra, rb), 1'b1, 1'b1, ae, tr);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge Clk); InValid = 1'b0; OutReady = ($urandom_range(0, 1) != 0); #3;
      end
    end

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(negedge Clk); InValid = 1'b0; OutReady = 1'b1; #4;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle 32-bit ALU: same 4-bit ALUControl opcode map, width generalised, two new shift/compare ops, and a real multi-cycle signed multiply producing a full double-width product.
Registered outputs with valid/ready handshakes on input and output, so the pipeline can stall on the multiply.
Sits in the EX stage; the hazard unit stalls on InReady=0.

Parameters:
WIDTH, 32, operand/result width; power of 2, >= 8
SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0]

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
InValid  input  1  operands/opcode valid
InReady  output  1  block can accept an operation this cycle
ALUControl  input  4  opcode
A  input  WIDTH  operand A
B  input  WIDTH  operand B / shift amount
OutValid  output  1  result registers valid
OutReady  input  1  consumer takes the result this cycle
ALUResult  output  WIDTH  result (low product word for MUL)
Hi  output  WIDTH  high product word for MUL; 0 otherwise
Zero  output  1  ALUResult == 0
Overflow  output  1  signed overflow on ADD/SUB; 0 otherwise
Error  output  1  illegal opcode

Behaviour:
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL A<<B[SHW-1:0], 5 SRL, 6 SUB A-B, 7 SLT signed (result 1/0), 8 ROTL, 9 ROTR, 10 SRA (new), 11 SLTU (new), 12 NOR, 13 and 14 illegal, 15 MUL signed.
- Shift and rotate amounts use B[SHW-1:0] only.
- A rotate by 0 returns A unchanged.
- Illegal opcode: ALUResult=0, Hi=0, Zero=1, Error=1; it is a single-cycle op.
- Reset (async, Reset_n=0): OutValid=0, ALUResult=0, Hi=0, Zero=0, Overflow=0, Error=0, state IDLE, counter 0.
- A reset during MUL aborts the operation with no result. InReady=1 on the first edge after release.
- InReady = (state==IDLE) && (!OutValid || OutReady). It is combinational from state and OutReady.
- An operation is accepted on a rising edge with InValid && InReady. Inputs are ignored otherwise.
- Single-cycle op: the result registers load on the accept edge; OutValid=1 from that edge. Latency 1.
- Back-to-back single-cycle ops with OutReady=1 sustain one result per cycle.
- MUL accept: state goes to BUSY and OutValid clears (any previous result was consumed that same edge).
- MUL capture: |A|, |B| and the sign flag are captured. Counter = WIDTH.
- BUSY: one radix-2 shift-add iteration per cycle. After WIDTH iterations the product is negated if signs differ, then loaded as Hi:ALUResult.
- MUL completion: OutValid=1, Overflow=0, Error=0, state IDLE. OutValid rises exactly WIDTH+1 edges after the accept edge.
- Most-negative operands (e.g. A=B=0x80000000) yield the exact 2*WIDTH-bit product 0x40000000_00000000.
- Output hold: while OutValid && !OutReady, all outputs are held stable and InReady=0.
- An OutReady && !new-accept edge clears OutValid; the data registers keep their values.
- Zero and Error/Overflow are registered with the result. Zero reflects ALUResult only, never Hi.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_AND..OP_MUL, OP_SRA=10, OP_SLTU=11) and state encoding IDLE/BUSY.
- One sub-module, alu_seq_multiplier: start/busy/done, unsigned shift-add core of WIDTH iterations plus sign fix.
- The combinational op mux stays in the top level.

Test Plan:
1. A=716, B=26, ops 0,1,2,3,6 with OutReady=1 -> ALUResult 8, 734, 742, 726, 690, each one cycle after accept. Back-to-back ops give no bubbles.
2. A=716, B=26, op 4 -> 0x30000000; op 9 with A=0xDD6AD59A, B=4 -> 0xADD6AD59. Op 10 with A=0x80000000, B=31 -> 0xFFFFFFFF. Op 11 with A=1, B=0xFFFFFFFF -> 1; op 7 with the same operands -> 0.
3. Op 2 with A=0x7FFFFFFF, B=1 -> ALUResult 0x80000000, Overflow=1; op 14 -> Error=1, Zero=1, ALUResult 0.
4. Op 15 with A=716, B=26 -> Hi:ALUResult = 0:0x000048B8 after exactly 33 edges, InReady=0 throughout. A=-3, B=5 -> Hi=0xFFFFFFFF, ALUResult=0xFFFFFFF1.
5. OutReady=0 for 5 cycles after a result -> outputs stable, InReady=0. The op issued in the same cycle OutReady rises is accepted.
6. Reset_n low mid-MUL at cycle 10 -> all outputs 0 immediately (asynchronous). A fresh op 2 after release completes normally.
